// File: rtl/game_flow_fsm.sv
`default_nettype none
// game_flow_fsm: top-level game sequencer tracking world, level and lives,
// with fixed-length banner states and a one-cycle level reload strobe.
module game_flow_fsm #(
    parameter int LEVELS_PER_WORLD = 4,
    parameter int NUM_WORLDS       = 4,
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 9,
    parameter int HOLD_CYCLES      = 100000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_btn_i,
    input  logic       level_complete_i,
    input  logic       player_died_i,
    output logic [2:0] game_status_o,
    output logic [1:0] world_o,
    output logic [2:0] level_o,
    output logic [3:0] lives_o,
    output logic       level_load_o,
    output logic       playing_o
);

    localparam int         CW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
    localparam logic [1:0] LAST_WORLD = 2'(NUM_WORLDS - 1);
    localparam logic [3:0] LIVES_INIT = 4'(START_LIVES);
    localparam logic [3:0] LIVES_MAX  = 4'(MAX_LIVES);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_PLAY      = 3'd1,
        ST_LEVEL_INC = 3'd2,
        ST_WORLD_INC = 3'd3,
        ST_LIVES_INC = 3'd4,
        ST_LOSE      = 3'd5,
        ST_WIN       = 3'd6,
        ST_RESPAWN   = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    world_q, world_d;
    logic [2:0]    level_q, level_d;
    logic [3:0]    lives_q, lives_d;
    logic          load_q, load_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sync_q;
    logic          start_pulse;
    logic          hold_state;
    logic          hold_done;

    // sync_q[0..1] form the synchronizer; sync_q[2] is the edge-detect history
    assign start_pulse = sync_q[1] & ~sync_q[2];
    assign hold_state  = (state_q == ST_LEVEL_INC) || (state_q == ST_WORLD_INC) ||
                         (state_q == ST_LIVES_INC) || (state_q == ST_RESPAWN);
    assign hold_done   = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        world_d = world_q;
        level_d = level_q;
        lives_d = lives_q;
        load_d  = 1'b0;
        case (state_q)
            ST_START: begin
                if (start_pulse) begin
                    world_d = 2'd0;
                    level_d = 3'd0;
                    lives_d = LIVES_INIT;
                    state_d = ST_PLAY;
                    load_d  = 1'b1;
                end
            end
            ST_PLAY: begin
                // The reload cycle masks both gameplay inputs.
                if (!load_q) begin
                    if (level_complete_i) begin
                        if (level_q < LAST_LEVEL)      state_d = ST_LEVEL_INC;
                        else if (world_q < LAST_WORLD) state_d = ST_WORLD_INC;
                        else                           state_d = ST_WIN;
                    end else if (player_died_i) begin
                        lives_d = lives_q - 4'd1;
                        state_d = (lives_q == 4'd1) ? ST_LOSE : ST_RESPAWN;
                    end
                end
            end
            ST_LEVEL_INC: begin
                if (hold_done) begin
                    level_d = level_q + 3'd1;
                    state_d = ST_PLAY;
                    load_d  = 1'b1;
                end
            end
            ST_WORLD_INC: begin
                if (hold_done) begin
                    world_d = world_q + 2'd1;
                    level_d = 3'd0;
                    state_d = ST_LIVES_INC;
                end
            end
            ST_LIVES_INC: begin
                if (hold_done) begin
                    if (lives_q < LIVES_MAX) lives_d = lives_q + 4'd1;
                    state_d = ST_PLAY;
                    load_d  = 1'b1;
                end
            end
            ST_RESPAWN: begin
                if (hold_done) begin
                    state_d = ST_PLAY;
                    load_d  = 1'b1;
                end
            end
            ST_LOSE, ST_WIN: begin
                if (start_pulse) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase

        if (!hold_state || (state_d != state_q)) cnt_d = '0;
        else                                     cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_START;
            world_q <= 2'd0;
            level_q <= 3'd0;
            lives_q <= LIVES_INIT;
            load_q  <= 1'b0;
            cnt_q   <= '0;
            sync_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            world_q <= world_d;
            level_q <= level_d;
            lives_q <= lives_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[1:0], start_btn_i};
        end
    end

    assign game_status_o = state_q;
    assign world_o       = world_q;
    assign level_o       = level_q;
    assign lives_o       = lives_q;
    assign level_load_o  = load_q;
    assign playing_o     = (state_q == ST_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_game_flow_fsm.sv
`default_nettype none
// tb_game_flow_fsm: scenario tasks plus randomized play, checked against a
// game-rule reference model that counts banner time down in whole cycles.
module tb_game_flow_fsm;

    localparam int LPW   = 4;
    localparam int NW    = 4;
    localparam int START = 3;
    localparam int MAXL  = 9;
    localparam int HOLD  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_i = 1'b0, lc_i = 1'b0, pd_i = 1'b0;

    logic [2:0] game_status, level, game_status2, level2;
    logic [1:0] world, world2;
    logic [3:0] lives, lives2;
    logic       level_load, playing, level_load2, playing2;

    always #5 clk = ~clk;

    game_flow_fsm #(.LEVELS_PER_WORLD(LPW), .NUM_WORLDS(NW), .START_LIVES(START),
                    .MAX_LIVES(MAXL), .HOLD_CYCLES(HOLD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_btn_i(btn_i),
        .level_complete_i(lc_i), .player_died_i(pd_i),
        .game_status_o(game_status), .world_o(world), .level_o(level),
        .lives_o(lives), .level_load_o(level_load), .playing_o(playing));

    // Second copy starting at the lives ceiling, used for the saturation check.
    game_flow_fsm #(.LEVELS_PER_WORLD(LPW), .NUM_WORLDS(NW), .START_LIVES(MAXL),
                    .MAX_LIVES(MAXL), .HOLD_CYCLES(HOLD)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_btn_i(btn_i),
        .level_complete_i(lc_i), .player_died_i(pd_i),
        .game_status_o(game_status2), .world_o(world2), .level_o(level2),
        .lives_o(lives2), .level_load_o(level_load2), .playing_o(playing2));

    int vectors = 0;
    int errs    = 0;

    // Reference model: game status codes, counters and a banner countdown.
    logic [2:0] m_status;
    logic [1:0] m_world;
    logic [2:0] m_level;
    logic [3:0] m_lives;
    logic       m_load;
    int         m_left;
    logic [2:0] m_h;

    wire [13:0] dut_vec = {game_status, world, level, lives, level_load, playing};

    function automatic logic [13:0] exp_vec();
        return {m_status, m_world, m_level, m_lives, m_load, (m_status == 3'd1)};
    endfunction

    task automatic model_reset();
        m_status = 3'd0; m_world = 2'd0; m_level = 3'd0;
        m_lives = 4'(START); m_load = 1'b0; m_left = 0; m_h = 3'b000;
    endtask

    task automatic model_edge();
        logic pulse, was_load;
        pulse    = m_h[1] && !m_h[2];
        was_load = m_load;
        m_load   = 1'b0;
        case (m_status)
            3'd0: if (pulse) begin
                m_world = 0; m_level = 0; m_lives = 4'(START); m_status = 3'd1; m_load = 1'b1;
            end
            3'd1: if (!was_load) begin
                if (lc_i) begin
                    if (int'(m_level) < LPW - 1)      begin m_status = 3'd2; m_left = HOLD; end
                    else if (int'(m_world) < NW - 1)  begin m_status = 3'd3; m_left = HOLD; end
                    else                              m_status = 3'd6;
                end else if (pd_i) begin
                    m_lives = m_lives - 4'd1;
                    if (m_lives == 0) m_status = 3'd5;
                    else begin m_status = 3'd7; m_left = HOLD; end
                end
            end
            3'd2, 3'd3, 3'd4, 3'd7: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    case (m_status)
                        3'd2: begin m_level = m_level + 3'd1; m_status = 3'd1; m_load = 1'b1; end
                        3'd3: begin m_world = m_world + 2'd1; m_level = 0; m_status = 3'd4; m_left = HOLD; end
                        3'd4: begin
                            if (int'(m_lives) < MAXL) m_lives = m_lives + 4'd1;
                            m_status = 3'd1; m_load = 1'b1;
                        end
                        default: begin m_status = 3'd1; m_load = 1'b1; end
                    endcase
                end
            end
            default: if (pulse) m_status = 3'd0;
        endcase
        m_h = {m_h[1:0], btn_i};
    endtask

    task automatic tick(input logic lc, input logic pd, input logic btn);
        lc_i = lc; pd_i = pd; btn_i = btn;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 1'b0; btn_i = 0; lc_i = 0; pd_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (dut_vec !== {3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0}) begin
            errs++; $display("FAIL reset_values: dut=%h exp=%h", dut_vec, {3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1);
            vectors++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL start_edge c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
        end
        vectors++;
        if (game_status !== 3'd1 || level_load !== 1'b1 || lives !== 4'd3) begin
            errs++; $display("FAIL start_third_edge: status=%0d load=%b lives=%0d exp 1/1/3", game_status, level_load, lives);
        end
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 1);
            vectors++;
            if (dut_vec !== exp_vec() || level_load !== 1'b0) begin errs++; $display("FAIL start_held c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
        end
        tick(0, 0, 0);
    endtask

    task automatic test_level_inc();
        int n2 = 0;
        tick(1, 0, 0);
        for (int i = 0; i < 20 && !(m_status == 3'd1 && m_load); i++) begin
            if (game_status == 3'd2) n2++;
            vectors++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL level_inc c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
            tick(0, 0, 0);
        end
        if (game_status == 3'd2) n2++;
        vectors++;
        if (n2 != HOLD || level !== 3'd1 || level_load !== 1'b1) begin
            errs++; $display("FAIL level_inc_hold: cycles=%0d level=%0d load=%b exp %0d/1/1", n2, level, level_load, HOLD);
        end
        tick(1, 0, 0);
        vectors++;
        if (dut_vec !== exp_vec() || game_status !== 3'd1 || level !== 3'd1) begin
            errs++; $display("FAIL lc_in_load_cycle: dut=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_world_inc();
        int n3 = 0, n4 = 0;
        for (int i = 0; i < 200 && !(m_world == 2'd1 && m_status == 3'd1 && !m_load); i++) begin
            tick((m_status == 3'd1) && !m_load && (m_world == 2'd0), 0, 0);
            if (game_status == 3'd3) n3++;
            if (game_status == 3'd4) n4++;
            vectors++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL world_inc c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
        end
        vectors++;
        if (n3 != HOLD || n4 != HOLD || world !== 2'd1 || level !== 3'd0 || lives !== 4'd4) begin
            errs++; $display("FAIL world_inc_result: n3=%0d n4=%0d world=%0d level=%0d lives=%0d exp 4/4/1/0/4",
                             n3, n4, world, level, lives);
        end
        vectors++;
        if (lives2 !== 4'd9 || world2 !== 2'd1) begin
            errs++; $display("FAIL lives_saturate: lives=%0d world=%0d exp 9/1", lives2, world2);
        end
    endtask

    task automatic test_death();
        int n7 = 0;
        tick(0, 1, 0);
        for (int i = 0; i < 20 && !(m_status == 3'd1 && !m_load); i++) begin
            if (game_status == 3'd7) n7++;
            vectors++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL respawn c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
            tick(0, 0, 0);
        end
        vectors++;
        if (n7 != HOLD || lives !== 4'd3 || world !== 2'd1 || level !== 3'd0) begin
            errs++; $display("FAIL respawn_result: n7=%0d lives=%0d world=%0d level=%0d exp 4/3/1/0", n7, lives, world, level);
        end
        for (int i = 0; i < 200 && m_status != 3'd5; i++) begin
            tick((m_status == 3'd1) ? 1'b0 : 1'($urandom_range(0, 1)), (m_status == 3'd1) && !m_load, 0);
            vectors++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL to_lose c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            vectors++;
            if (dut_vec !== exp_vec() || game_status !== 3'd5 || lives !== 4'd0) begin
                errs++; $display("FAIL lose_frozen c%0d: dut=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 8; i++) tick(0, 0, i < 3);
            vectors++;
            if (dut_vec !== exp_vec() || game_status !== ((g == 0) ? 3'd0 : 3'd1) || lives !== ((g == 0) ? 4'd0 : 4'd3)) begin
                errs++; $display("FAIL lose_restart g%0d: dut=%h exp=%h", g, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_both_and_win();
        tick(1, 1, 0);
        vectors++;
        if (dut_vec !== exp_vec() || game_status !== 3'd2 || lives !== 4'd3) begin
            errs++; $display("FAIL lc_priority: dut=%h exp=%h", dut_vec, exp_vec());
        end
        for (int i = 0; i < 2000 && m_status != 3'd6; i++) begin
            tick((m_status == 3'd1) && !m_load, 0, 0);
            vectors++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL to_win c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            vectors++;
            if (dut_vec !== exp_vec() || game_status !== 3'd6 || world !== 2'd3 || level !== 3'd3) begin
                errs++; $display("FAIL win_frozen c%0d: dut=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        for (int i = 0; i < 8; i++) tick(0, 0, i < 3);
        vectors++;
        if (dut_vec !== exp_vec() || game_status !== 3'd0) begin
            errs++; $display("FAIL win_to_start: dut=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 8; i++) tick(0, 0, i < 3);
        tick(1, 0, 0);
        tick(0, 0, 0);
        vectors++;
        if (game_status !== 3'd2) begin errs++; $display("FAIL pre_reset_state: status=%0d exp 2", game_status); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dut_vec !== {3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0}) begin
            errs++; $display("FAIL async_reset: dut=%h exp=%h", dut_vec, {3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0});
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            vectors++;
            if (dut_vec !== exp_vec() || game_status !== 3'd0) begin errs++; $display("FAIL idle_after_reset c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_random();
        logic b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) b = ~b;
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, b);
            vectors++;
            if (dut_vec !== exp_vec()) begin errs++; $display("FAIL random c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                vectors++;
                if (dut_vec !== exp_vec()) begin errs++; $display("FAIL random_reset c%0d: dut=%h exp=%h", i, dut_vec, exp_vec()); end
                @(negedge clk) rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_level_inc();
        test_world_inc();
        test_death();
        test_both_and_win();
        test_mid_reset();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
